moving_average_n: RTL
=====================

// Module: moving_average_n
//
// PURPOSE
//   Parametrised streaming moving-average filter: signed samples in, mean of the last
//   2**LOG2_DEPTH accepted samples out. Successor to the fixed 3-tap, 8-bit averager,
//   adding configurable width and depth, valid qualification, selectable rounding,
//   warm-up mode and a synchronous clear. Sits in the sample datapath between the
//   input register stage and downstream filters.
//
// PARAMETERS
//   WIDTH       8  signed sample width, in and out (>=2)
//   LOG2_DEPTH  2  window depth D = 2**LOG2_DEPTH (1..8)
//   ROUND       0  0: floor (arithmetic shift); 1: round half toward +inf
//   FILL_MODE   0  0: window starts zero-filled, every input produces output;
//                  1: out_valid suppressed until D samples have been accepted
//
// PORTS
//   system1000      in   1      clock, all logic on rising edge
//   system1000_rst  in   1      reset, synchronous, active-high
//   clear           in   1      synchronous window flush (same effect as reset)
//   in_valid        in   1      in_data accepted this cycle
//   in_data         in   WIDTH  signed sample
//   out_valid       out  1      out_data valid this cycle (one-cycle pulse per accepted sample)
//   out_data        out  WIDTH  signed window average
//   full            out  1      D samples accepted since last reset/clear
//
// BEHAVIOUR
//   - Storage: circular buffer of D entries, write pointer wr_ptr (LOG2_DEPTH bits),
//     running sum SUM (WIDTH+LOG2_DEPTH bits signed), fill counter cnt (0..D, saturates).
//   - Accept (in_valid=1, no reset/clear): SUM <= SUM + in_data - buf[wr_ptr];
//     buf[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (wraps D-1 -> 0); cnt <= min(cnt+1, D).
//   - Evicted entry is the oldest sample, or 0 for unfilled slots (buffer zeroed on reset/clear).
//   - in_valid=0: no state change, out_valid=0, out_data holds its last value.
//   - Latency: 1 cycle. out_valid/out_data registered in the accept cycle, computed from the new SUM.
//   - Averaging: computed in WIDTH+LOG2_DEPTH+1 bits.
//     ROUND=0: SUM_new >>> LOG2_DEPTH. ROUND=1: (SUM_new + 2**(LOG2_DEPTH-1)) >>> LOG2_DEPTH.
//     ROUND=1 with LOG2_DEPTH=0 is a pass-through.
//     Result always fits WIDTH, so no saturation is needed. Take the low WIDTH bits.
//   - FILL_MODE=0: out_valid=1 on every accept; early outputs average against zeros.
//   - FILL_MODE=1: out_valid=1 only on accepts where the post-update cnt==D.
//   - full = (cnt==D), registered.
//   - Reset (system1000_rst=1), any cycle including mid-stream: buf, SUM, wr_ptr, cnt,
//     out_data, out_valid and full all go to 0.
//   - clear=1: identical to reset. If in_valid=1 in the same cycle, clear wins, the sample
//     is discarded and out_valid=0.
//   - reset takes priority over clear and in_valid.
//   - Back-to-back accepts are fully supported (throughput 1 sample/cycle); no backpressure.
//
// TESTING  (WIDTH=8, LOG2_DEPTH=2 unless stated)
//   1 FILL_MODE=0, ROUND=0: accept 4,8,12,16 consecutively -> out 1,3,6,10, out_valid each
//     cycle; full=1 after 4th.
//   2 ROUND=0: accept -1 x4 -> out -1,-1,-1,-1. ROUND=1: same stimulus -> out 0,0,-1,-1.
//   3 Extremes: 127 x4 -> final 127; then -128 x4 -> final -128; no wrap/overflow.
//   4 FILL_MODE=1: accept 10,20,30,40,50 -> out_valid low for first 3; outs 25 then 35.
//   5 Bubbles: 4,_,_,8,_,12,16 (_ = in_valid=0) -> outputs match test 1; out_valid only on accepts.
//   6 Accept 100 x3, then clear=1 with in_valid=1 -> no output, full=0;
//     next accept 8 -> out 2 (FILL_MODE=0). Repeat using system1000_rst mid-stream.

Source files
------------

// File: rtl/moving_average_n.sv
// moving_average_n: streaming moving-average filter over the last 2**LOG2_DEPTH
// accepted signed samples. Circular buffer plus running sum, one-cycle latency,
// selectable floor/round-half-up, optional warm-up suppression and sync clear.
//
// Handshake: in_valid qualifies in_data for exactly one cycle and is always
// accepted (no backpressure). out_valid is a one-cycle pulse that follows each
// accepted sample, except that clear/reset discards the sample and, with
// FILL_MODE=1, the pulse is suppressed until the window holds DEPTH samples.
// out_data holds its last value while out_valid is low.
module moving_average_n #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0,
  parameter int FILL_MODE  = 0
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;      // running-sum width
  localparam int AW    = SW + 1;                  // averaging width (room for rounding add)
  localparam int CW    = LOG2_DEPTH + 1;          // fill counter width, counts 0..DEPTH
  localparam int RSH   = (LOG2_DEPTH > 0) ? LOG2_DEPTH - 1 : 0;

  localparam logic [CW-1:0]        CNT_MAX = CW'(DEPTH);
  // Half an LSB of the output; zero for floor mode or a single-entry window.
  localparam logic signed [AW-1:0] RND     = (ROUND != 0 && LOG2_DEPTH > 0) ?
                                             (AW'(1) <<< RSH) : AW'(0);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    sum_next;
  logic signed [AW-1:0]    avg_full;
  logic signed [WIDTH-1:0] avg;
  logic                    window_full_next;

  // Next running sum, fill count and window average for a sample accepted now.
  always_comb begin
    sum_next         = sum + SW'(in_data) - SW'(mem[wr_ptr]);
    cnt_next         = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    window_full_next = (cnt_next == CNT_MAX);
    // The mean of WIDTH-bit samples always fits WIDTH bits, so truncation is exact.
    avg_full         = (AW'(sum_next) + RND) >>> LOG2_DEPTH;
    avg              = avg_full[WIDTH-1:0];
  end

  // Window state and registered outputs; reset and clear both flush everything.
  always_ff @(posedge system1000) begin
    if (system1000_rst || clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (in_valid) begin
      mem[wr_ptr] <= in_data;
      sum         <= sum_next;
      wr_ptr      <= wr_ptr + LOG2_DEPTH'(1);
      cnt         <= cnt_next;
      full        <= window_full_next;
      out_data    <= avg;
      out_valid   <= (FILL_MODE == 0) || window_full_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
